// File: rtl/fetch_pkg.sv
// Shared state encoding and field constants for the MIPS instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    SKID  = 2'd1,
    DRAIN = 2'd2
  } FetchState;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          OPCODE_MSB = 31;
  localparam int          OPCODE_LSB = 26;
  localparam int          FUNCT_MSB  = 5;
  localparam int          FUNCT_LSB  = 0;
  localparam logic [31:0] PC_INC     = 32'd4;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read channel: the fetch stage is master, the memory is slave.
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid.sv
// One-entry {instr, pc4} skid buffer that parks a fetched word while decode stalls.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  // A flush outranks a load so a word acked in a redirect cycle never survives.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (clear_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      pc4_d   = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc4_d   = pc4_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS fetch stage with IF/ID register, decode-stall skid and redirect squash.
// Optional FETCH_ALIGN_CHECK_EN: word-align redirect targets and flag misaligned ones.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_if.master     imem,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        addr_err
);

  FetchState   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drainAddr_q, drainAddr_d;
  logic        ifValid_q, ifValid_d;
  logic [31:0] ifInstr_q, ifInstr_d;
  logic [31:0] ifPc4_q, ifPc4_d;

  logic        skidLoad, skidUnload, skidClear, skidValid;
  logic [31:0] skidInstr, skidPc4;
  logic        take;
  logic [31:0] pcPlus4, target;

  assign take    = !ifValid_q || !stall;
  assign pcPlus4 = pc_q + PC_INC;

  // While draining, the abandoned address stays on the bus until memory answers.
  assign imem.imem_req  = rst_n && (state_q != SKID);
  assign imem.imem_addr = (state_q == DRAIN) ? drainAddr_q : pc_q;

`ifdef FETCH_ALIGN_CHECK_EN
  logic addrErr_q;

  assign target = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) addrErr_q <= 1'b0;
    else        addrErr_q <= addrErr_q | (redirect && (redirect_pc[1:0] != 2'b00));
  end

  assign addr_err = addrErr_q;
`else
  assign target   = redirect_pc;
  assign addr_err = 1'b0;
`endif

  fetch_skid u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (skidLoad),
    .unload_i (skidUnload),
    .clear_i  (skidClear),
    .instr_i  (imem.imem_rdata),
    .pc4_i    (pcPlus4),
    .valid_o  (skidValid),
    .instr_o  (skidInstr),
    .pc4_o    (skidPc4)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drainAddr_d = drainAddr_q;
    ifValid_d   = ifValid_q;
    ifInstr_d   = ifInstr_q;
    ifPc4_d     = ifPc4_q;
    skidLoad    = 1'b0;
    skidUnload  = 1'b0;
    skidClear   = 1'b0;
    if (redirect) begin
      ifValid_d = 1'b0;
      ifInstr_d = NOP_INSTR;
      ifPc4_d   = '0;
      skidClear = 1'b1;
      pc_d      = target;
      if (imem.imem_req && !imem.imem_ack) begin
        state_d     = DRAIN;
        drainAddr_d = imem.imem_addr;
      end else begin
        state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem.imem_ack) begin
            pc_d = pcPlus4;
            if (take) begin
              ifValid_d = 1'b1;
              ifInstr_d = imem.imem_rdata;
              ifPc4_d   = pcPlus4;
            end else begin
              skidLoad = 1'b1;
              state_d  = SKID;
            end
          end else if (ifValid_q && !stall) begin
            ifValid_d = 1'b0;
            ifInstr_d = NOP_INSTR;
            ifPc4_d   = '0;
          end
        end
        SKID: begin
          if (!stall) begin
            ifValid_d  = skidValid;
            ifInstr_d  = skidInstr;
            ifPc4_d    = skidPc4;
            skidUnload = 1'b1;
            state_d    = FETCH;
          end
        end
        DRAIN: begin
          if (imem.imem_ack) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      drainAddr_q <= RESET_PC;
      ifValid_q   <= 1'b0;
      ifInstr_q   <= NOP_INSTR;
      ifPc4_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drainAddr_q <= drainAddr_d;
      ifValid_q   <= ifValid_d;
      ifInstr_q   <= ifInstr_d;
      ifPc4_q     <= ifPc4_d;
    end
  end

  assign if_valid = ifValid_q;
  assign if_instr = ifInstr_q;
  assign if_pc4   = ifPc4_q;
  assign opcode   = ifInstr_q[OPCODE_MSB:OPCODE_LSB];
  assign funct    = ifInstr_q[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-randomised memory, program-order scoreboard, directed corners.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        addr_err;

  fetch_if bus ();

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc4      (if_pc4),
    .opcode      (opcode),
    .funct       (funct),
    .addr_err    (addr_err)
  );

  int          testsRun    = 0;
  int          testsFailed = 0;
  int          consumed    = 0;
  int          memLat      = 0;
  logic [63:0] expQ[$];
  logic [31:0] nextPushPc  = RESET_PC;
  logic        expAddrErr  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: word 0 is a known ADD so the first decode is predictable.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h0124_4020;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rN, input logic st, input logic rd, input logic [31:0] tgt);
    rst_n       = rN;
    stall       = st;
    redirect    = rd;
    redirect_pc = tgt;
  endtask

  // Reference model: the program-order stream decode should see, restarted on reset or redirect.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      expQ.delete();
      nextPushPc = RESET_PC;
      expAddrErr = 1'b0;
    end else if (redirect) begin
      expQ.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      nextPushPc = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) expAddrErr = 1'b1;
`else
      nextPushPc = redirect_pc;
`endif
    end
    while (expQ.size() < 16) begin
      expQ.push_back({memWord(nextPushPc), nextPushPc + 32'd4});
      nextPushPc = nextPushPc + 32'd4;
    end
    #1;
  endtask

  // Memory responder: picks a latency per request and tolerates a dropped request.
  initial begin
    bit memBusy;
    int memCnt;
    memBusy         = 1'b0;
    memCnt          = 0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #2;
      if (bus.imem_ack) memBusy = 1'b0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'hDEAD_BEEF;
      if (!bus.imem_req) begin
        memBusy = 1'b0;
      end else begin
        if (!memBusy) begin
          memBusy = 1'b1;
          memCnt  = (memLat < 0) ? int'($urandom_range(2, 0)) : memLat;
        end
        if (memCnt == 0) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = memWord(bus.imem_addr);
        end else begin
          memCnt--;
        end
      end
    end
  end

  // Monitor: each word decode accepts must be the next one in program order.
  initial begin
    logic [63:0] e;
    logic        prevRst, prevReq, prevAck;
    logic [31:0] prevAddr;
    prevRst  = 1'b0;
    prevReq  = 1'b0;
    prevAck  = 1'b0;
    prevAddr = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (if_valid && !stall) begin
          if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL sb_empty: got pc4 %h expected no word at %0t", if_pc4, $time);
          end else begin
            e = expQ.pop_front();
            checkOutput("sb_instr", if_instr, e[63:32]);
            checkOutput("sb_pc4", if_pc4, e[31:0]);
            checkOutput("sb_opcode", 32'(opcode), 32'(e[63:58]));
            checkOutput("sb_funct", 32'(funct), 32'(e[37:32]));
            consumed++;
          end
        end else if (!if_valid) begin
          checkOutput("empty_instr", if_instr, 32'h0);
        end
        if (prevRst && prevReq && !prevAck) begin
          checkOutput("hold_req", 32'(bus.imem_req), 32'd1);
          checkOutput("hold_addr", bus.imem_addr, prevAddr);
        end
        checkOutput("addr_err", 32'(addr_err), 32'(expAddrErr));
      end
      prevRst  = rst_n;
      prevReq  = bus.imem_req;
      prevAck  = bus.imem_ack;
      prevAddr = bus.imem_addr;
    end
  end

  initial begin
    logic        rN, st, rd;
    logic [31:0] tgt;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    memLat = 0;
    tick();
    tick();
    checkOutput("rst_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_instr", if_instr, 32'h0);
    checkOutput("rst_pc4", if_pc4, 32'h0);
    checkOutput("rst_req", 32'(bus.imem_req), 32'd0);
    checkOutput("rst_addr_err", 32'(addr_err), 32'd0);

    // Zero-wait streaming from RESET_PC
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("c0_req", 32'(bus.imem_req), 32'd1);
    checkOutput("c0_addr", bus.imem_addr, 32'h0);
    checkOutput("c0_valid", 32'(if_valid), 32'd0);
    tick();
    checkOutput("c1_valid", 32'(if_valid), 32'd1);
    checkOutput("c1_instr", if_instr, 32'h0124_4020);
    checkOutput("c1_funct", 32'(funct), 32'h20);
    checkOutput("c1_opcode", 32'(opcode), 32'h0);
    checkOutput("c1_pc4", if_pc4, 32'h4);
    checkOutput("c1_addr", bus.imem_addr, 32'h4);
    tick();
    checkOutput("c2_pc4", if_pc4, 32'h8);
    checkOutput("c2_addr", bus.imem_addr, 32'h8);
    tick();
    checkOutput("c3_pc4", if_pc4, 32'hC);

    // Three stalled cycles with an ack arriving: the word parks in the skid
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("skid_req", 32'(bus.imem_req), 32'd0);
    checkOutput("skid_valid", 32'(if_valid), 32'd1);
    checkOutput("skid_pc4", if_pc4, 32'hC);
    tick();
    tick();
    checkOutput("skid_hold_pc4", if_pc4, 32'hC);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    memLat = 2;
    tick();
    checkOutput("unskid_pc4", if_pc4, 32'h10);
    checkOutput("unskid_addr", bus.imem_addr, 32'h10);

    // Redirect while the request is outstanding and the ack comes two cycles late
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("drain_valid", 32'(if_valid), 32'd0);
    checkOutput("drain_addr", bus.imem_addr, 32'h10);
    tick();
    checkOutput("drain_valid2", 32'(if_valid), 32'd0);
    tick();
    memLat = 0;
    checkOutput("drained_valid", 32'(if_valid), 32'd0);
    checkOutput("drained_addr", bus.imem_addr, 32'h100);
    tick();
    checkOutput("target_pc4", if_pc4, 32'h104);

    // Redirect in the same cycle as an ack
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0200);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("rdack_valid", 32'(if_valid), 32'd0);
    checkOutput("rdack_addr", bus.imem_addr, 32'h200);
    tick();
    checkOutput("rdack_pc4", if_pc4, 32'h204);

    // Reset while parked in SKID with a live instruction
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("pre_rst_req", 32'(bus.imem_req), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("skrst_valid", 32'(if_valid), 32'd0);
    checkOutput("skrst_instr", if_instr, 32'h0);
    checkOutput("skrst_pc4", if_pc4, 32'h0);
    checkOutput("skrst_req", 32'(bus.imem_req), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("skrst_addr", bus.imem_addr, RESET_PC);
    tick();
    checkOutput("post_rst_pc4", if_pc4, 32'h4);

    // Misaligned redirect target
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0102);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("align_err", 32'(addr_err), 32'd1);
    checkOutput("align_addr", bus.imem_addr, 32'h100);
`else
    checkOutput("align_err", 32'(addr_err), 32'd0);
    checkOutput("align_addr", bus.imem_addr, 32'h102);
`endif

    // Randomised traffic: stalls, redirects (some near the 32-bit wrap), rare resets
    memLat = -1;
    for (int i = 0; i < 800; i++) begin
      tick();
      rN  = ($urandom_range(199, 0) != 0);
      st  = ($urandom_range(3, 0) == 0);
      rd  = rN && ($urandom_range(9, 0) == 0);
      tgt = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF8 : {20'h0, 12'($urandom_range(4095, 0))};
      applyStimulus(rN, st, rd, tgt);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("consumed_enough", 32'(consumed >= 50), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the MIPS datapath. Holds the PC, issues word reads to instruction memory over a req/ack handshake, and presents the fetched instruction with its decoded `opcode`/`funct` fields directly to the control decoder. Supports decode-stage stalls through a one-entry skid buffer, and supports redirects (jump, JR, taken branch) with in-flight squash.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `imem_req` out 1: read request; once raised, held with `imem_addr` stable until `imem_ack`.
- `imem_addr` out 32: word address of the current request.
- `imem_ack` in 1: `imem_rdata` valid this cycle; only meaningful while `imem_req`=1.
- `imem_rdata` in 32: instruction word.
- `stall` in 1: decode cannot accept; IF/ID holds.
- `redirect` in 1: jump/JR/taken-branch redirect.
- `redirect_pc` in 32: new fetch PC, sampled when `redirect`=1.
- `if_valid` out 1: IF/ID holds a live instruction.
- `if_instr` out 32: IF/ID instruction.
- `if_pc4` out 32: PC+4 of `if_instr`.
- `opcode` out 6: `if_instr[31:26]`, combinational from the register.
- `funct` out 6: `if_instr[5:0]`, combinational from the register.
- `addr_err` out 1: misaligned redirect flag (see Configuration).

## Operation
- States: FETCH (request may be issued/outstanding), SKID (word buffered, no request), DRAIN (outstanding request to be discarded).
- Accept condition: `take = !if_valid || !stall`.
- FETCH: `imem_req`=1 with `imem_addr`=PC. On `imem_ack`:
  - if `take`: IF/ID <= {rdata, PC+4}, `if_valid`<=1, PC<=PC+4, stay in FETCH.
  - else: skid <= {rdata, PC+4}, PC<=PC+4, go to SKID.
- FETCH, no ack, `if_valid && !stall`: `if_valid`<=0, since the instruction was consumed and no replacement has arrived.
- SKID: `imem_req`=0. When `!stall`: IF/ID <= skid, then go to FETCH.
- Redirect has the highest priority in every state. Effects: `if_valid`<=0, skid cleared, PC<=`redirect_pc`.
  - Request outstanding with no ack this cycle: go to DRAIN.
  - Otherwise: go to FETCH, and any ack data in this cycle is discarded.
- DRAIN: `imem_req` stays at 1 with the old address. On ack, discard data and go to FETCH at the new PC. A second redirect during DRAIN overwrites PC and remains in DRAIN.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- An empty IF/ID shows `if_instr`=32'h0. Control decodes this as SLL $0, which is harmless, but consumers must still gate on `if_valid`.

## Timing
- Reset (`rst_n`=0 at an edge): PC=`RESET_PC`, state FETCH, `if_valid`=0, `if_instr`=0, `if_pc4`=0, skid empty, `addr_err`=0.
  - `imem_req`=0 while `rst_n`=0; it rises in the first cycle after release.
- Reset mid-transaction abandons the outstanding request. Memory must tolerate a dropped req.
- Ack may arrive in the first cycle of req, giving 1-cycle fetch-to-`if_valid`. Zero-wait memory sustains 1 instr/cycle.
- Redirect in cycle N: `if_valid`=0 in N+1. Earliest new-PC `imem_req` is N+1 from FETCH/SKID, or the cycle after the drained ack.
- `stall` never blocks redirect. Simultaneous `stall`+`redirect` results in a flush.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - a redirect with `redirect_pc[1:0]`≠0 sets `addr_err` (sticky until reset);
  - the PC is loaded with `{redirect_pc[31:2],2'b00}`.
- Undefined: `addr_err` is tied to 0, and `redirect_pc` is loaded unmodified.

## Structure
- `fetch_pkg`: state enum (FETCH/SKID/DRAIN), `NOP_INSTR`=32'h0, `OPCODE_MSB/LSB`=31/26, `FUNCT_MSB/LSB`=5/0, `PC_INC`=4.
- Sub-module `fetch_skid`: one-entry {instr, pc4} buffer with load/unload/clear and a valid bit. The IF/ID register and FSM live in `fetch_stage`.

## Test plan
- Reset release, zero-wait ack every cycle:
  - `imem_addr` reads 0, 4, 8;
  - `if_valid`=1 from the second cycle;
  - `if_pc4`=4, 8, 12;
  - `opcode`/`funct` match the loaded words (e.g. 32'h0124_4020 gives funct=6'b100000).
- `stall`=1 for 3 cycles with ack pending:
  - the second word enters SKID and `imem_req`=0;
  - on stall release the instruction order is preserved and no word is lost or duplicated.
- `redirect`=1, `redirect_pc`=32'h0000_0100, while a request is outstanding and the ack is 2 cycles late:
  - the acked word is discarded (`if_valid` stays 0);
  - the next `imem_addr`=32'h100.
- `redirect` and `imem_ack` in the same cycle: the data is dropped, `if_valid`=0 in the next cycle, and the next request goes to the target.
- `rst_n`=0 while in SKID with `if_valid`=1: in the next cycle all outputs are at reset values and PC=`RESET_PC`.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 32'h0000_0102: `addr_err`=1 and `imem_addr`=32'h100. Without the macro, `addr_err` stays 0.
